// File: rtl/spi_sram_controller_pkg.sv
// rtl/spi_sram_controller_pkg.sv - shared constants, state encoding and frame builder for the SPI SRAM bridge
package spi_sram_controller_pkg;

    localparam logic [7:0] CMD_READ     = 8'h03;
    localparam logic [7:0] CMD_WRITE    = 8'h02;
    localparam int         WORD_SIZE    = 16;
    localparam int         ADDRESS_SIZE = 18;
    localparam int         FRAME_BITS   = 48;
    localparam int         HEADER_BITS  = FRAME_BITS - WORD_SIZE;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Byte address is the word address shifted left by one; read frames send zeros in the data phase.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic                 is_write,
        input logic [15:0]          word_addr,
        input logic [WORD_SIZE-1:0] data,
        input logic [7:0]           cmd_rd,
        input logic [7:0]           cmd_wr
    );
        return {is_write ? cmd_wr : cmd_rd, 7'b0, word_addr, 1'b0,
                is_write ? data : {WORD_SIZE{1'b0}}};
    endfunction

endpackage

// File: rtl/spi_sram_controller.sv
// rtl/spi_sram_controller.sv - one CPU word request per 48-bit SPI frame to a sequential-mode serial SRAM
module spi_sram_controller #(
    parameter int         ADDR_W    = spi_sram_controller_pkg::ADDRESS_SIZE,
    parameter int         DATA_W    = spi_sram_controller_pkg::WORD_SIZE,
    parameter logic [7:0] CMD_READ  = spi_sram_controller_pkg::CMD_READ,
    parameter logic [7:0] CMD_WRITE = spi_sram_controller_pkg::CMD_WRITE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [ADDR_W-1:0] mem_address,
    input  logic [DATA_W-1:0] mem_write_value,
    input  logic              mem_write_enable,
    input  logic              mem_request,
    output logic [DATA_W-1:0] mem_read_value,
    output logic              mem_request_complete,
    output logic              sram_cs,
    output logic              sram_si,
    input  logic              sram_so
);
    import spi_sram_controller_pkg::*;

    localparam logic [5:0] LAST_BIT = 6'(FRAME_BITS - 1);
    localparam logic [5:0] RX_FIRST = 6'(HEADER_BITS);

    state_t                  state;
    logic [5:0]              bit_cnt;
    logic [FRAME_BITS-1:0]   tx_shift;
    logic [DATA_W-1:0]       rx_shift;
    logic                    is_write;
    logic [FRAME_BITS-1:0]   load_frame;
    logic                    unused_addr_hi;

    assign load_frame     = build_frame(mem_write_enable, mem_address[15:0], mem_write_value,
                                        CMD_READ, CMD_WRITE);
    assign unused_addr_hi = ^mem_address[ADDR_W-1:16];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                <= ST_IDLE;
            bit_cnt              <= 6'd0;
            tx_shift             <= '0;
            rx_shift             <= '0;
            is_write             <= 1'b0;
            sram_cs              <= 1'b1;
            sram_si              <= 1'b0;
            mem_request_complete <= 1'b0;
            mem_read_value       <= '0;
        end else if (ena) begin
            case (state)
                ST_IDLE: begin
                    mem_request_complete <= 1'b0;
                    sram_cs              <= 1'b1;
                    sram_si              <= 1'b0;
                    if (mem_request) begin
                        // First bit goes straight to the pin; tx_shift then holds the remainder MSB-aligned.
                        sram_si  <= load_frame[FRAME_BITS-1];
                        tx_shift <= {load_frame[FRAME_BITS-2:0], 1'b0};
                        sram_cs  <= 1'b0;
                        bit_cnt  <= 6'd0;
                        is_write <= mem_write_enable;
                        state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    sram_si  <= tx_shift[FRAME_BITS-1];
                    tx_shift <= {tx_shift[FRAME_BITS-2:0], 1'b0};
                    if (bit_cnt >= RX_FIRST) begin
                        rx_shift <= {rx_shift[DATA_W-2:0], sram_so};
                    end
                    if (bit_cnt == LAST_BIT) begin
                        state                <= ST_DONE;
                        sram_cs              <= 1'b1;
                        sram_si              <= 1'b0;
                        mem_request_complete <= 1'b1;
                        if (!is_write) begin
                            mem_read_value <= {rx_shift[DATA_W-2:0], sram_so};
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 6'd1;
                    end
                end
                ST_DONE: begin
                    // Always pass through IDLE so cs stays high between back-to-back frames.
                    mem_request_complete <= 1'b0;
                    bit_cnt              <= 6'd0;
                    state                <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_sram_controller.sv
// tb/tb_spi_sram_controller.sv - scoreboard bench with serial SRAM model and word-level reference memory
module tb_spi_sram_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b0;
    logic [17:0] mem_address = '0;
    logic [15:0] mem_write_value = '0;
    logic        mem_write_enable = 1'b0;
    logic        mem_request = 1'b0;
    logic [15:0] mem_read_value;
    logic        mem_request_complete;
    logic        sram_cs;
    logic        sram_si;
    logic        sram_so = 1'b0;

    spi_sram_controller dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .ena                  (ena),
        .mem_address          (mem_address),
        .mem_write_value      (mem_write_value),
        .mem_write_enable     (mem_write_enable),
        .mem_request          (mem_request),
        .mem_read_value       (mem_read_value),
        .mem_request_complete (mem_request_complete),
        .sram_cs              (sram_cs),
        .sram_si              (sram_si),
        .sram_so              (sram_so)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [15:0] waddr;
        logic [15:0] data;
    } txn_t;

    txn_t        sb[$];
    logic [15:0] ref_words [int];
    logic [7:0]  model_mem [int];

    int          tests = 0;
    int          fails = 0;
    int          ecnt = 0;
    int          rcnt = 0;
    bit          sck_en = 1'b0;
    int          frame_start_e = 0;
    int          start_r = 0;
    bit          hold_req = 1'b0;
    logic [15:0] exp_last_read = '0;
    logic [47:0] last_frame = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] mem_byte(input int a);
        return model_mem.exists(a) ? model_mem[a] : 8'h00;
    endfunction

    function automatic logic [47:0] exp_frame(input txn_t t);
        logic [23:0] ba;
        ba = 24'(t.waddr) * 24'd2;
        return {t.we ? 8'h02 : 8'h03, ba, t.we ? t.data : 16'h0000};
    endfunction

    // Reference: word-addressed memory; the upper two request address bits never reach the SRAM.
    task automatic push_txn(input logic we, input logic [17:0] addr, input logic [15:0] data);
        txn_t t;
        int   key;
        key     = int'(addr) % 65536;
        t.we    = we;
        t.waddr = 16'(key);
        if (we) begin
            ref_words[key] = data;
            t.data = data;
        end else begin
            t.data = ref_words.exists(key) ? ref_words[key] : 16'h0000;
        end
        sb.push_back(t);
    endtask

    initial forever begin
        @(posedge clk);
        rcnt   <= rcnt + 1;
        ecnt   <= ena ? ecnt + 1 : ecnt;
        sck_en <= ena;
    end

    // Serial SRAM model: SCK is gated by ena, so a clock cycle counts only if the preceding edge was enabled.
    initial begin : sram_model
        int          bitn;
        int          m_ba;
        logic [47:0] sh;
        logic [15:0] rd_word;
        bitn = 0; m_ba = 0; sh = '0; rd_word = '0;
        forever begin
            @(negedge clk);
            if (!rst_n || sram_cs) begin
                bitn    = 0;
                sram_so = 1'b0;
            end else if (sck_en) begin
                if (bitn < 48) sh[47-bitn] = sram_si;
                if (bitn == 31) begin
                    m_ba    = int'(sh[39:16]);
                    rd_word = {mem_byte(m_ba), mem_byte(m_ba + 1)};
                end
                if (bitn >= 32 && bitn < 48 && sh[47:40] == 8'h03) sram_so = rd_word[47-bitn];
                if (bitn == 47) begin
                    last_frame = sh;
                    if (sh[47:40] == 8'h02) begin
                        model_mem[m_ba]     = sh[15:8];
                        model_mem[m_ba + 1] = sh[7:0];
                    end
                end
                bitn++;
            end
        end
    end

    initial begin : monitor
        txn_t t;
        bit   prev_cpl;
        prev_cpl = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_cpl = 1'b0;
            end else begin
                if (mem_request_complete) begin
                    check("complete_pulse_width", 64'(prev_cpl), 64'd0);
                    if (sb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_complete: got complete with no request outstanding, expected none");
                    end else begin
                        t = sb.pop_front();
                        check("latency_cycles", 64'(ecnt - frame_start_e), 64'd48);
                        check("si_frame", 64'(last_frame), 64'(exp_frame(t)));
                        check("cs_high_at_done", 64'(sram_cs), 64'd1);
                        if (t.we) begin
                            check("read_value_kept_on_write", 64'(mem_read_value), 64'(exp_last_read));
                            check("sram_byte_even", 64'(mem_byte(2 * int'(t.waddr))), 64'(t.data[15:8]));
                            check("sram_byte_odd", 64'(mem_byte(2 * int'(t.waddr) + 1)), 64'(t.data[7:0]));
                        end else begin
                            check("read_value", 64'(mem_read_value), 64'(t.data));
                            exp_last_read = t.data;
                        end
                    end
                    if (hold_req) frame_start_e = ecnt + 2;
                end
                prev_cpl = mem_request_complete;
            end
        end
    end

    task automatic issue(input logic we, input logic [17:0] addr, input logic [15:0] data,
                         input bit push, input bit scramble);
        @(negedge clk);
        ena              = 1'b1;
        mem_write_enable = we;
        mem_address      = addr;
        mem_write_value  = data;
        mem_request      = 1'b1;
        if (push) push_txn(we, addr, data);
        @(negedge clk);
        frame_start_e = ecnt;
        start_r       = rcnt;
        if (scramble) begin
            mem_write_enable = 1'($urandom);
            mem_address      = 18'($urandom);
            mem_write_value  = 16'($urandom);
            mem_request      = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic wait_done(input bit rnd_ena);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (mem_request_complete) seen = 1'b1;
            else if (rnd_ena) ena = ($urandom_range(0, 3) != 0);
        end
        ena = 1'b1;
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL complete_timeout: got no complete in 400 cycles, expected one");
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL global_timeout: got simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        txn_t        st;
        logic [47:0] fr;
        repeat (3) @(negedge clk);
        check("reset_cs", 64'(sram_cs), 64'd1);
        check("reset_si", 64'(sram_si), 64'd0);
        check("reset_complete", 64'(mem_request_complete), 64'd0);
        check("reset_read_value", 64'(mem_read_value), 64'd0);
        rst_n = 1'b1;
        ena   = 1'b1;

        issue(1'b1, 18'h00012, 16'hBEEF, 1'b1, 1'b0);
        wait_done(1'b0);
        check("write_latency_raw", 64'(rcnt - start_r), 64'd48);
        mem_request = 1'b0;

        issue(1'b0, 18'h00012, 16'h0000, 1'b1, 1'b0);
        wait_done(1'b0);
        mem_request = 1'b0;

        model_mem[0] = 8'h12;
        model_mem[1] = 8'h34;
        ref_words[0] = 16'h1234;
        hold_req = 1'b1;
        issue(1'b0, 18'h00000, 16'h0000, 1'b1, 1'b0);
        push_txn(1'b0, 18'h00000, 16'h0000);
        wait_done(1'b0);
        @(negedge clk);
        check("cs_gap_between_frames", 64'(sram_cs), 64'd1);
        wait_done(1'b0);
        mem_request = 1'b0;
        @(negedge clk);
        hold_req = 1'b0;

        st.we = 1'b0; st.waddr = 16'h0012; st.data = 16'h0000;
        fr = exp_frame(st);
        issue(1'b0, 18'h00012, 16'h0000, 1'b1, 1'b0);
        repeat (6) @(negedge clk);
        ena = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_cs_low", 64'(sram_cs), 64'd0);
            check("stall_si_frozen", 64'(sram_si), 64'(fr[41]));
        end
        ena = 1'b1;
        wait_done(1'b0);
        check("stall_latency_raw", 64'(rcnt - start_r), 64'd58);
        mem_request = 1'b0;

        issue(1'b1, 18'h00012, 16'hDEAD, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        #2;
        rst_n       = 1'b0;
        mem_request = 1'b0;
        #1;
        check("abort_cs_async", 64'(sram_cs), 64'd1);
        check("abort_complete", 64'(mem_request_complete), 64'd0);
        check("abort_read_value", 64'(mem_read_value), 64'd0);
        exp_last_read = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_complete", 64'(mem_request_complete), 64'd0);
        end
        rst_n = 1'b1;
        issue(1'b0, 18'h00012, 16'h0000, 1'b1, 1'b0);
        wait_done(1'b0);
        mem_request = 1'b0;

        issue(1'b1, 18'h3FFFF, 16'h5A5A, 1'b1, 1'b0);
        wait_done(1'b0);
        mem_request = 1'b0;
        issue(1'b0, 18'h0FFFF, 16'h0000, 1'b1, 1'b0);
        wait_done(1'b0);
        mem_request = 1'b0;

        for (int n = 0; n < 16; n++) begin
            logic [17:0] a;
            a = {2'($urandom), 16'($urandom_range(0, 7)) * 16'h1111};
            issue(1'($urandom), a, 16'($urandom), 1'b1, 1'b1);
            wait_done(1'b1);
            mem_request = 1'b0;
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
